// File: rtl/ad9361_capture_ctrl_if.sv
// AXI-stream style beat bundle shared by the serializer input and the
// consumer output of the AD9361 capture sequencer.
interface ad9361_capture_ctrl_if #(
    parameter int DATA_WIDTH = 96
);
    logic                  tvalid;
    logic                  tready;
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tlast;

    // Producer side of a stream.
    modport master (
        output tvalid,
        output tdata,
        output tlast,
        input  tready
    );

    // Consumer side of a stream.
    modport slave (
        input  tvalid,
        input  tdata,
        input  tlast,
        output tready
    );
endinterface

// File: rtl/ad9361_capture_ctrl.sv
// AD9361 capture sequencer: after start, discards a number of serializer
// beats, forwards a fixed-length burst with tlast on its final beat and then
// idles or re-arms. The ADC stream is never stalled, so beats that cannot be
// placed in the single output register during a capture are dropped and
// counted in a saturating overflow counter.
module ad9361_capture_ctrl #(
    parameter int DATA_WIDTH  = 96,
    parameter int COUNT_WIDTH = 16,
    parameter int OVF_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [COUNT_WIDTH-1:0] cfg_length_i,
    input  logic [COUNT_WIDTH-1:0] cfg_skip_i,
    input  logic                   cfg_continuous_i,
    input  logic                   start_i,
    input  logic                   abort_i,
    ad9361_capture_ctrl_if.slave   s_axis,
    ad9361_capture_ctrl_if.master  m_axis,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [OVF_WIDTH-1:0]   overflow_count_o
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SKIP    = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DRAIN   = 2'd3
    } state_t;

    state_t                  state_q,   state_d;
    logic [COUNT_WIDTH-1:0]  len_q,     len_d;
    logic [COUNT_WIDTH-1:0]  skip_q,    skip_d;
    logic [COUNT_WIDTH-1:0]  idx_q,     idx_d;
    logic                    cont_q,    cont_d;
    logic                    aborted_q, aborted_d;
    logic                    m_valid_q, m_valid_d;
    logic [DATA_WIDTH-1:0]   m_data_q,  m_data_d;
    logic                    m_last_q,  m_last_d;
    logic                    done_q,    done_d;
    logic [OVF_WIDTH-1:0]    ovf_q,     ovf_d;
    logic                    tready_q;

    logic                    s_beat;
    logic                    drain;
    logic                    out_free;
    logic [COUNT_WIDTH-1:0]  last_idx;
    logic                    take;
    logic [COUNT_WIDTH-1:0]  take_idx;

    // The serializer's own tlast carries no meaning here.
    logic unused_s_tlast;
    assign unused_s_tlast = s_axis.tlast;

    // A beat exists whenever the serializer presents one; we are always ready.
    assign s_beat   = s_axis.tvalid & tready_q;
    assign drain    = m_valid_q & m_axis.tready;
    assign out_free = ~m_valid_q | drain;
    // Length 0 wraps naturally to all-ones, giving a 2^COUNT_WIDTH burst.
    assign last_idx = len_q - 1'b1;

    // Ready rises on the first clock after reset release and stays high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tready_q <= 1'b0;
        end else begin
            tready_q <= 1'b1;
        end
    end

    // State, counters and output register update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            len_q     <= '0;
            skip_q    <= '0;
            idx_q     <= '0;
            cont_q    <= 1'b0;
            aborted_q <= 1'b0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_last_q  <= 1'b0;
            done_q    <= 1'b0;
            ovf_q     <= '0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            skip_q    <= skip_d;
            idx_q     <= idx_d;
            cont_q    <= cont_d;
            aborted_q <= aborted_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_last_q  <= m_last_d;
            done_q    <= done_d;
            ovf_q     <= ovf_d;
        end
    end

    // Next-state, beat-take and overflow decisions.
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        skip_d    = skip_q;
        idx_d     = idx_q;
        cont_d    = cont_q;
        aborted_d = aborted_q;
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        m_last_d  = m_last_q;
        done_d    = 1'b0;
        ovf_d     = ovf_q;
        take      = 1'b0;
        take_idx  = idx_q;

        // An accepted beat empties the output register; new data may refill it below.
        if (drain) begin
            m_valid_d = 1'b0;
            m_last_d  = 1'b0;
        end

        if (abort_i) begin
            // Abort beats start; any held beat is still delivered, but without done.
            cont_d = 1'b0;
            if (out_free) begin
                state_d   = ST_IDLE;
                aborted_d = 1'b0;
            end else begin
                state_d   = ST_DRAIN;
                aborted_d = 1'b1;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        len_d     = cfg_length_i;
                        cont_d    = cfg_continuous_i;
                        skip_d    = cfg_skip_i;
                        idx_d     = '0;
                        ovf_d     = '0;
                        aborted_d = 1'b0;
                        state_d   = (cfg_skip_i == '0) ? ST_CAPTURE : ST_SKIP;
                    end
                end
                ST_SKIP: begin
                    if (s_beat) begin
                        if (skip_q == COUNT_WIDTH'(1)) begin
                            state_d = ST_CAPTURE;
                            idx_d   = '0;
                        end else begin
                            skip_d = skip_q - 1'b1;
                        end
                    end
                end
                ST_CAPTURE: begin
                    if (s_beat) begin
                        if (out_free) begin
                            take = 1'b1;
                        end else if (ovf_q != '1) begin
                            ovf_d = ovf_q + 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (drain) begin
                        if (aborted_q) begin
                            state_d   = ST_IDLE;
                            aborted_d = 1'b0;
                        end else begin
                            done_d = 1'b1;
                            if (cont_q) begin
                                // Re-arm without a gap: a beat on this cycle opens the next burst.
                                state_d  = ST_CAPTURE;
                                idx_d    = '0;
                                take_idx = '0;
                                take     = s_beat;
                            end else begin
                                state_d = ST_IDLE;
                            end
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase

            if (take) begin
                m_valid_d = 1'b1;
                m_data_d  = s_axis.tdata;
                m_last_d  = (take_idx == last_idx);
                idx_d     = take_idx + 1'b1;
                state_d   = (take_idx == last_idx) ? ST_DRAIN : ST_CAPTURE;
            end
        end
    end

    assign s_axis.tready    = tready_q;
    assign m_axis.tvalid    = m_valid_q;
    assign m_axis.tdata     = m_data_q;
    assign m_axis.tlast     = m_last_q;
    assign busy_o           = (state_q != ST_IDLE);
    assign done_o           = done_q;
    assign overflow_count_o = ovf_q;

endmodule

// File: tb/tb_ad9361_capture_ctrl.sv
// Self-checking bench for ad9361_capture_ctrl: expected output beats are
// queued as stimulus is driven and compared as the consumer accepts them.
module tb_ad9361_capture_ctrl;

    localparam int DW = 96;
    localparam int CW = 4;
    localparam int OW = 4;

    typedef logic [DW:0] beat_t;   // {tlast, tdata}

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [CW-1:0] cfg_length = '0;
    logic [CW-1:0] cfg_skip = '0;
    logic          cfg_continuous = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          busy;
    logic          done;
    logic [OW-1:0] ovf;

    ad9361_capture_ctrl_if #(.DATA_WIDTH(DW)) s_if ();
    ad9361_capture_ctrl_if #(.DATA_WIDTH(DW)) m_if ();

    ad9361_capture_ctrl #(
        .DATA_WIDTH (DW),
        .COUNT_WIDTH(CW),
        .OVF_WIDTH  (OW)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .cfg_length_i    (cfg_length),
        .cfg_skip_i      (cfg_skip),
        .cfg_continuous_i(cfg_continuous),
        .start_i         (start),
        .abort_i         (abort),
        .s_axis          (s_if),
        .m_axis          (m_if),
        .busy_o          (busy),
        .done_o          (done),
        .overflow_count_o(ovf)
    );

    always #5 clk = ~clk;

    int    total = 0;
    int    bad = 0;
    beat_t exp_q[$];
    int    cyc = 0;
    int    last_acc_cyc = -100;
    int    done_cnt = 0;
    bit    hold_pending = 1'b0;
    beat_t held;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic expect_beat(input bit last, input int unsigned d);
        beat_t b;
        b = {last, DW'(d)};
        exp_q.push_back(b);
    endtask

    // One clock: apply inputs, pass the edge, drop single-cycle pulses.
    task automatic drive(input bit v, input int unsigned d, input bit r);
        s_if.tvalid = v;
        s_if.tdata  = DW'(d);
        m_if.tready = r;
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic do_start(input int len, input int skip, input bit cont);
        cfg_length     = CW'(len);
        cfg_skip       = CW'(skip);
        cfg_continuous = cont;
        start          = 1'b1;
        drive(1'b0, 0, 1'b1);
    endtask

    // Consumer-side monitor: scoreboard pops, hold stability, done latency.
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            hold_pending = 1'b0;
        end else begin
            if (hold_pending) begin
                check("hold_valid", 128'(m_if.tvalid), 128'd1);
                check("hold_beat", 128'({m_if.tlast, m_if.tdata}), 128'(held));
            end
            if (m_if.tvalid && m_if.tready) begin
                check("beat_expected", 128'(exp_q.size() != 0), 128'd1);
                if (exp_q.size() != 0) begin
                    beat_t e;
                    e = exp_q.pop_front();
                    check("beat", 128'({m_if.tlast, m_if.tdata}), 128'(e));
                    $display("beat accepted: data=%0h last=%0b", m_if.tdata, m_if.tlast);
                end
                if (m_if.tlast) last_acc_cyc = cyc;
            end
            hold_pending = m_if.tvalid && !m_if.tready;
            held = {m_if.tlast, m_if.tdata};
            if (done) begin
                done_cnt++;
                check("done_latency", 128'(cyc - last_acc_cyc), 128'd1);
            end
        end
    end

    initial begin
        s_if.tvalid = 1'b0;
        s_if.tdata  = '0;
        s_if.tlast  = 1'b0;
        m_if.tready = 1'b0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 128'(busy), 128'd0);
        check("rst_done", 128'(done), 128'd0);
        check("rst_ovf", 128'(ovf), 128'd0);
        check("rst_tvalid", 128'(m_if.tvalid), 128'd0);
        check("rst_tlast", 128'(m_if.tlast), 128'd0);
        check("rst_tdata", 128'(m_if.tdata), 128'd0);
        check("rst_s_tready", 128'(s_if.tready), 128'd0);
        rst_n = 1'b1;
        drive(1'b0, 0, 1'b1);
        drive(1'b0, 0, 1'b1);
        check("s_tready_up", 128'(s_if.tready), 128'd1);

        // 1: length 4, skip 2, data = n -> 2,3,4,5
        do_start(4, 2, 1'b0);
        check("t1_busy_run", 128'(busy), 128'd1);
        for (int i = 0; i < 10; i++) begin
            if (i >= 2 && i <= 5) expect_beat(i == 5, i);
            drive(1'b1, i, 1'b1);
        end
        check("t1_busy_end", 128'(busy), 128'd0);
        check("t1_done_cnt", 128'(done_cnt), 128'd1);
        check("t1_ovf", 128'(ovf), 128'd0);
        check("t1_q_empty", 128'(exp_q.size()), 128'd0);

        // 2: tready low for 3 cycles, two beats dropped
        do_start(4, 0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            if (i == 0 || (i >= 3 && i <= 5)) expect_beat(i == 5, 100 + i);
            drive(1'b1, 100 + i, i > 2);
        end
        check("t2_ovf", 128'(ovf), 128'd2);
        check("t2_done_cnt", 128'(done_cnt), 128'd2);
        check("t2_q_empty", 128'(exp_q.size()), 128'd0);

        // 3: continuous, length 3, skip 1, stopped by abort on the 3rd tlast
        do_start(3, 1, 1'b1);
        for (int i = 0; i < 13; i++) begin
            if (i >= 1 && i <= 9) expect_beat((i % 3) == 0, 200 + i);
            if (i == 10) abort = 1'b1;
            drive(1'b1, 200 + i, 1'b1);
        end
        check("t3_busy_end", 128'(busy), 128'd0);
        check("t3_done_cnt", 128'(done_cnt), 128'd4);
        check("t3_ovf", 128'(ovf), 128'd0);
        check("t3_q_empty", 128'(exp_q.size()), 128'd0);

        // 4: abort with tready low, then start+abort together
        do_start(8, 0, 1'b0);
        expect_beat(1'b0, 300);
        drive(1'b1, 300, 1'b1);
        expect_beat(1'b0, 301);
        drive(1'b1, 301, 1'b1);
        abort = 1'b1;
        drive(1'b1, 302, 1'b0);
        drive(1'b1, 303, 1'b0);
        check("t4_busy_hold", 128'(busy), 128'd1);
        drive(1'b1, 304, 1'b0);
        drive(1'b1, 305, 1'b1);
        drive(1'b1, 306, 1'b1);
        check("t4_busy_end", 128'(busy), 128'd0);
        check("t4_no_done", 128'(done_cnt), 128'd4);
        check("t4_ovf", 128'(ovf), 128'd0);
        check("t4_q_empty", 128'(exp_q.size()), 128'd0);
        cfg_length = CW'(4);
        cfg_skip   = '0;
        start = 1'b1;
        abort = 1'b1;
        drive(1'b1, 310, 1'b1);
        check("t4_start_abort", 128'(busy), 128'd0);
        for (int i = 0; i < 3; i++) drive(1'b1, 311 + i, 1'b1);
        check("t4_still_idle", 128'(busy), 128'd0);

        // 5a: length 0 -> 16-beat burst; start and cfg change while busy ignored
        do_start(0, 0, 1'b0);
        for (int i = 0; i < 18; i++) begin
            if (i < 16) expect_beat(i == 15, 400 + i);
            if (i == 3) begin
                cfg_length = CW'(2);
                start = 1'b1;
            end
            drive(1'b1, 400 + i, 1'b1);
        end
        check("t5_busy_end", 128'(busy), 128'd0);
        check("t5_done_cnt", 128'(done_cnt), 128'd5);
        check("t5_q_empty", 128'(exp_q.size()), 128'd0);

        // 5b: overflow saturation under long tready low
        do_start(2, 0, 1'b0);
        expect_beat(1'b0, 500);
        drive(1'b1, 500, 1'b1);
        for (int i = 1; i <= 20; i++) begin
            drive(1'b1, 500 + i, 1'b0);
            if (i == 14) check("t5_ovf_14", 128'(ovf), 128'd14);
        end
        check("t5_ovf_sat", 128'(ovf), 128'd15);
        expect_beat(1'b1, 521);
        drive(1'b1, 521, 1'b1);
        drive(1'b1, 522, 1'b1);
        drive(1'b1, 523, 1'b1);
        check("t5_ovf_hold", 128'(ovf), 128'd15);
        check("t5b_done_cnt", 128'(done_cnt), 128'd6);
        check("t5b_q_empty", 128'(exp_q.size()), 128'd0);

        // 6: reset mid-capture, then a clean burst
        do_start(8, 0, 1'b0);
        expect_beat(1'b0, 600);
        drive(1'b1, 600, 1'b1);
        expect_beat(1'b0, 601);
        drive(1'b1, 601, 1'b1);
        drive(1'b1, 602, 1'b0);
        drive(1'b1, 603, 1'b0);
        check("t6_ovf_pre", 128'(ovf), 128'd2);
        check("t6_busy_pre", 128'(busy), 128'd1);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("t6_rst_tvalid", 128'(m_if.tvalid), 128'd0);
        check("t6_rst_tlast", 128'(m_if.tlast), 128'd0);
        check("t6_rst_tdata", 128'(m_if.tdata), 128'd0);
        check("t6_rst_busy", 128'(busy), 128'd0);
        check("t6_rst_done", 128'(done), 128'd0);
        check("t6_rst_ovf", 128'(ovf), 128'd0);
        check("t6_rst_s_tready", 128'(s_if.tready), 128'd0);
        drive(1'b0, 0, 1'b0);
        drive(1'b0, 0, 1'b0);
        rst_n = 1'b1;
        drive(1'b0, 0, 1'b1);
        drive(1'b0, 0, 1'b1);
        do_start(2, 0, 1'b0);
        check("t6_ovf_clean", 128'(ovf), 128'd0);
        expect_beat(1'b0, 700);
        drive(1'b1, 700, 1'b1);
        expect_beat(1'b1, 701);
        drive(1'b1, 701, 1'b1);
        drive(1'b1, 702, 1'b1);
        drive(1'b1, 703, 1'b1);
        drive(1'b0, 0, 1'b1);
        check("t6_done_cnt", 128'(done_cnt), 128'd7);
        check("t6_ovf_end", 128'(ovf), 128'd0);
        check("t6_busy_end", 128'(busy), 128'd0);
        check("t6_q_empty", 128'(exp_q.size()), 128'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
